// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller: prescaled digit scan with anti-ghost guard,
// double-buffered display data swapped only at frame boundaries, hex decode and leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000,
  parameter int GUARD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     blank_i,
  input  logic                  lz_en_i,
  input  logic                  load_i,
  output logic                  load_ack_o,
  output logic                  pending_o,
  output logic [7:0]            seg_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  frame_o
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SCAN_DIV - 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_stg_data;
  logic [DIGITS-1:0]   r_stg_dp;
  logic [DIGITS-1:0]   r_stg_blank;
  logic                r_stg_lz;
  logic [4*DIGITS-1:0] r_dsp_data;
  logic [DIGITS-1:0]   r_dsp_dp;
  logic [DIGITS-1:0]   r_dsp_blank;
  logic                r_dsp_lz;
  logic                r_pending;
  logic                r_ack;
  logic                r_frame;
  logic [7:0]          r_seg;
  logic [DIGITS-1:0]   r_an;

  logic                w_wrap;
  logic                w_pre_wrap;
  logic                w_guard;
  logic [DIGITS-1:0]   w_supp;
  logic [3:0]          w_nib;
  logic                w_dark;
  logic [7:0]          w_seg;
  logic [DIGITS-1:0]   w_an;

  // Active-low a..g glyphs; b and d lowercase so they stay distinct from 8 and 0.
  function automatic logic [6:0] f_hex_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign w_wrap     = (r_cnt == CNT_LAST) && (r_idx == IDX_LAST);
  assign w_pre_wrap = (r_cnt == CNT_PRE)  && (r_idx == IDX_LAST);

  generate
    if (GUARD == 0) begin : g_no_guard
      assign w_guard = 1'b0;
    end else begin : g_guard
      assign w_guard = (r_cnt < CNT_W'(GUARD));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A load in the boundary cycle lands in staging while the previous staging goes live.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stg_data  <= '0;
      r_stg_dp    <= '0;
      r_stg_blank <= '0;
      r_stg_lz    <= 1'b0;
      r_dsp_data  <= '0;
      r_dsp_dp    <= '0;
      r_dsp_blank <= '0;
      r_dsp_lz    <= 1'b0;
      r_pending   <= 1'b0;
      r_ack       <= 1'b0;
      r_frame     <= 1'b0;
    end else begin
      if (load_i) begin
        r_stg_data  <= data_i;
        r_stg_dp    <= dp_i;
        r_stg_blank <= blank_i;
        r_stg_lz    <= lz_en_i;
      end
      if (w_wrap) begin
        if (r_pending) begin
          r_dsp_data  <= r_stg_data;
          r_dsp_dp    <= r_stg_dp;
          r_dsp_blank <= r_stg_blank;
          r_dsp_lz    <= r_stg_lz;
        end
        r_pending <= load_i;
      end else if (load_i) begin
        r_pending <= 1'b1;
      end
      // Pre-decoded one cycle early so both pulses coincide with the boundary cycle.
      r_frame <= w_pre_wrap;
      r_ack   <= w_pre_wrap && (r_pending || load_i);
    end
  end

  always_comb begin
    logic v_run;
    v_run  = 1'b1;
    w_supp = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      v_run = v_run & (r_dsp_data[4*k +: 4] == 4'h0);
      if (k != 0) w_supp[k] = r_dsp_lz & v_run;
    end
  end

  assign w_nib  = r_dsp_data[{r_idx, 2'b00} +: 4];
  assign w_dark = r_dsp_blank[r_idx] | w_supp[r_idx];
  assign w_seg  = w_dark ? 8'hFF : {~r_dsp_dp[r_idx], f_hex_seg(w_nib)};
  assign w_an   = ~(DIGITS'(1) << r_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an  <= '1;
      r_seg <= 8'hFF;
    end else begin
      r_an  <= w_guard ? '1 : w_an;
      r_seg <= w_guard ? 8'hFF : w_seg;
    end
  end

  assign load_ack_o = r_ack;
  assign pending_o  = r_pending;
  assign seg_o      = r_seg;
  assign an_o       = r_an;
  assign frame_o    = r_frame;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: stimulus predicts ack cycles into a queue, a monitor
// checks every cycle against a frame/slot arithmetic model of the display.
module tb_seg7_scan_ctrl;
  localparam int D  = 4;
  localparam int S  = 4;
  localparam int G  = 1;
  localparam int FR = D * S;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_i;
  logic [3:0]  dp_i;
  logic [3:0]  blank_i;
  logic        lz_en_i;
  logic        load_i;
  logic        load_ack_o;
  logic        pending_o;
  logic [7:0]  seg_o;
  logic [3:0]  an_o;
  logic        frame_o;

  seg7_scan_ctrl #(.DIGITS(D), .SCAN_DIV(S), .GUARD(G)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .dp_i(dp_i), .blank_i(blank_i),
    .lz_en_i(lz_en_i), .load_i(load_i), .load_ack_o(load_ack_o), .pending_o(pending_o),
    .seg_o(seg_o), .an_o(an_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int k        = 0;
  int q_ack[$];

  logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic [15:0] ms_data, md_data, mp_data;
  logic [3:0]  ms_dp, md_dp, mp_dp, ms_bl, md_bl, mp_bl;
  logic        ms_lz, md_lz, mp_lz, m_pend;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, k);
  endtask

  // Glyph a digit should show, given the display contents of the previous cycle.
  function automatic logic [7:0] exp_glyph(int slot);
    logic [3:0] nib;
    logic       supp;
    logic [7:0] g;
    nib  = mp_data[slot*4 +: 4];
    supp = mp_lz && (slot != 0);
    for (int j = slot; j < D; j++) if (mp_data[j*4 +: 4] != 4'h0) supp = 1'b0;
    if (mp_bl[slot] || supp) return 8'hFF;
    g = GLYPH[nib];
    if (mp_dp[slot]) g[7] = 1'b0;
    return g;
  endfunction

  task automatic model_reset();
    {ms_data, md_data, mp_data} = '0;
    {ms_dp, md_dp, mp_dp, ms_bl, md_bl, mp_bl} = '0;
    {ms_lz, md_lz, mp_lz, m_pend} = '0;
  endtask

  // Monitor: one pass per cycle at the falling edge.
  initial begin
    int p, slot, c;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_an", an_o, 4'hF);
        chk("rst_seg", seg_o, 8'hFF);
        chk("rst_pending", pending_o, 0);
        chk("rst_ack", load_ack_o, 0);
        chk("rst_frame", frame_o, 0);
        model_reset();
        q_ack.delete();
        k = 0;
      end else begin
        e_an  = 4'hF;
        e_seg = 8'hFF;
        if (k > 0) begin
          p    = (k - 1) % FR;
          slot = p / S;
          c    = p % S;
          if (c >= G) begin
            e_an  = 4'hF & ~(4'b0001 << slot);
            e_seg = exp_glyph(slot);
          end
        end
        chk("an", an_o, e_an);
        chk("seg", seg_o, e_seg);
        chk("frame", frame_o, (k % FR) == FR - 1);
        chk("pending", pending_o, m_pend);
        if (q_ack.size() > 0 && q_ack[0] == k) begin
          chk("load_ack", load_ack_o, 1);
          void'(q_ack.pop_front());
        end else if (load_ack_o) begin
          chk("load_ack_spurious", load_ack_o, 0);
        end
        mp_data = md_data; mp_dp = md_dp; mp_bl = md_bl; mp_lz = md_lz;
        if ((k % FR) == FR - 1) begin
          if (m_pend) begin
            md_data = ms_data; md_dp = ms_dp; md_bl = ms_bl; md_lz = ms_lz;
          end
          m_pend = 1'b0;
        end
        if (load_i) begin
          ms_data = data_i; ms_dp = dp_i; ms_bl = blank_i; ms_lz = lz_en_i;
          m_pend  = 1'b1;
        end
        k++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_i  = 1'b0;
    data_i  = 16'($urandom);
    dp_i    = 4'($urandom);
    blank_i = 4'($urandom);
    lz_en_i = 1'($urandom);
    step();
  endtask

  task automatic idle_n(int n);
    for (int i = 0; i < n; i++) idle();
  endtask

  task automatic wait_phase(int ph);
    for (int i = 0; i < 2 * FR && (k % FR) != ph; i++) idle();
  endtask

  // The ack lands on the first frame-boundary cycle strictly after the load cycle.
  task automatic do_load(logic [15:0] d, logic [3:0] dp, logic [3:0] bl, logic lz);
    int m;
    load_i = 1'b1; data_i = d; dp_i = dp; blank_i = bl; lz_en_i = lz;
    m = ((k % FR) == FR - 1) ? k + FR : k + (FR - 1 - (k % FR));
    if (q_ack.size() > 0 && q_ack[$] == m) void'(q_ack.pop_back());
    q_ack.push_back(m);
    step();
    load_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0; load_i = 1'b0; data_i = '0; dp_i = '0; blank_i = '0; lz_en_i = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    idle_n(40);

    wait_phase(5);
    do_load(16'h12AF, 4'h0, 4'h0, 1'b0);
    idle_n(24);

    wait_phase(2);
    do_load(16'h1111, 4'h0, 4'h0, 1'b0);
    idle_n(3);
    do_load(16'h2222, 4'h0, 4'h0, 1'b0);
    idle_n(36);

    do_load(16'h0050, 4'h0, 4'h0, 1'b1);
    idle_n(36);
    do_load(16'h0000, 4'h0, 4'h0, 1'b1);
    idle_n(36);
    do_load(16'h8888, 4'b0101, 4'b0010, 1'b0);
    idle_n(36);

    wait_phase(FR - 1);
    do_load(16'hABCD, 4'b1000, 4'h0, 1'b0);
    idle_n(40);

    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 9) == 0)
        do_load(16'($urandom), 4'($urandom),
                ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, 1'($urandom));
      else
        idle();
    end
    idle_n(40);

    wait_phase(4);
    do_load(16'h3C3C, 4'h0, 4'h0, 1'b0);
    idle();
    chk("pre_rst_pending", pending_o, 1);
    chk("pre_rst_an", an_o, 4'b1101);
    rst = 1'b0;
    #1;
    chk("async_rst_an", an_o, 4'hF);
    chk("async_rst_seg", seg_o, 8'hFF);
    chk("async_rst_pending", pending_o, 0);
    step();
    step();
    rst = 1'b1;
    idle_n(60);

    chk("ack_queue_drained", q_ack.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 8, number of multiplexed digits, legal range 2..16.
REQ-002 Parameter SCAN_DIV, default 100000, clk cycles per digit slot, legal range 4..2^20.
REQ-003 Parameter GUARD, default 2, anti-ghost cycles at the start of each slot with all anodes off, legal range 0..SCAN_DIV-2.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 data_i  in  4*DIGITS  hex nibbles; nibble k drives digit k, digit 0 rightmost.
REQ-007 dp_i  in  DIGITS  decimal point request per digit, 1 = lit.
REQ-008 blank_i  in  DIGITS  per-digit blank, 1 = digit dark including dp.
REQ-009 lz_en_i  in  1  leading-zero suppression enable.
REQ-010 load_i  in  1  one-cycle request to stage data_i/dp_i/blank_i/lz_en_i.
REQ-011 load_ack_o  out  1  one-cycle pulse when staged data becomes displayed.
REQ-012 pending_o  out  1  staged data not yet displayed.
REQ-013 seg_o  out  8  active-low segments, bit0=a..bit6=g, bit7=dp.
REQ-014 an_o  out  DIGITS  active-low anodes, at most one bit low.
REQ-015 frame_o  out  1  one-cycle pulse at every frame wrap.

Function
REQ-016 Prescaler cnt counts 0..SCAN_DIV-1 and wraps to 0; at wrap, digit index idx increments, DIGITS-1 -> 0.
REQ-017 frame_o SHALL pulse in the cycle in which idx goes DIGITS-1 -> 0 (the frame boundary).
REQ-018 On load_i, inputs are captured into a staging register on the same edge and pending_o goes to 1 on the next cycle.
REQ-019 At a frame boundary with pending set, staging is copied to the display register, pending clears and load_ack_o pulses in that cycle.
REQ-020 A load_i while pending is set overwrites staging; only one load_ack_o follows.
REQ-021 A load_i in the frame-boundary cycle is captured but is applied at the following boundary; the old staging is applied now.
REQ-022 Display register data SHALL never change mid-frame (tear-free).
REQ-023 Slot state: GUARD phase while cnt < GUARD (an_o all 1, seg_o 8'hFF), then DRIVE phase (an_o bit idx = 0).
REQ-024 Decoding: nibble 0..F maps to standard hex glyphs, with b, d in lowercase and A, C, E, F in uppercase; dp lit when dp_i bit set; seg_o is active-low.
REQ-025 Leading-zero suppression: with lz_en set, each digit from DIGITS-1 downward whose nibble is 0 is dark, up to the first nonzero nibble; digit 0 is never suppressed.
REQ-026 A suppressed or blanked digit drives seg_o = 8'hFF, but its anode still follows REQ-023.
REQ-027 seg_o and an_o are registered: one cycle of latency from cnt/idx to the pins.

Reset
REQ-028 While rst=0: cnt=0, idx=0, staging=0, display=0, pending_o=0, load_ack_o=0, frame_o=0, an_o all 1, seg_o=8'hFF.
REQ-029 Reset asserted mid-load or mid-frame discards staged data; after release, scanning restarts at idx 0 with cnt 0.
REQ-030 After release, the first scan displays all zeros with dp off and no blanks; with lz_en reset to 0, all digits show "0".

Verification
REQ-031 DIGITS=4, SCAN_DIV=4, GUARD=1, after reset -> an_o sequence per slot: 1111, 1110, 1110, 1110, then 1111, 1101, ...; frame_o pulses every 16 cycles.
REQ-032 Mid-frame load_i with data_i=16'h12AF -> pending_o=1 and the display is unchanged until the boundary; then load_ack_o pulses; digit0 seg_o=8'h8E (F), digit3 seg_o=8'hF9 (1).
REQ-033 Two loads in one frame (16'h1111 then 16'h2222) -> a single ack; the display shows 2222.
REQ-034 lz_en_i=1, data_i=16'h0050 -> digits 3 and 2 dark; digit 1 shows 5; digit 0 shows 0. data_i=16'h0000 -> only digit 0 lit.
REQ-035 load_i in the frame_o cycle -> no ack at that boundary; ack exactly DIGITS*SCAN_DIV cycles later.
REQ-036 rst pulled low during DRIVE with pending=1 -> outputs are immediately an_o=1111, seg_o=FF, pending_o=0; no ack after release.
